bus_arbiter: RTL and testbench

Two-master arbiter and transaction sequencer for the shared bus slave. Grants the slave to one requesting master at a time (round-robin), then sequences the slave through ready-wait, address strobe, write/read strobe and response-wait. Returns a one-cycle response or timeout-error pulse to the granted master. Sits between the master request logic and the slave control FSM, replacing free-running slave sequencing with request-driven sequencing.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_wait_timer.sv | 26 ++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding,
// master count and the master index type.
package bus_pkg;

  localparam int N_MASTERS = 2;

  typedef logic [0:0] mst_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_RESP  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } bus_state_t;

  function automatic logic [N_MASTERS-1:0] mst_onehot(input mst_idx_t idx);
    return idx[0] ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait counter for the slave ready / response phases; expired is asserted
// while the count equals TIMEOUT-1.
module bus_wait_timer #(
  parameter int TIMEOUT = 8,
  parameter int CW      = $clog2(TIMEOUT+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CW'(TIMEOUT-1));

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter that sequences the shared slave through
// ready-wait, address, data and response-wait, with timeout abort.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CW      = $clog2(TIMEOUT+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] m_req,
  input  logic [1:0] m_wr,
  input  logic       sl_rdy,
  input  logic       slrsp,
  output logic [1:0] m_gnt,
  output logic       sa,
  output logic       sw,
  output logic       sr,
  output logic [1:0] m_rsp,
  output logic [1:0] m_err
);

  // Handshake: a master holds m_req until it sees its m_gnt bit; from then on
  // m_req/m_wr are ignored and the transaction ends with exactly one m_rsp or
  // m_err pulse on that master's bit. sl_rdy and slrsp are level inputs
  // sampled only in GRANT and RESP respectively.

  bus_state_t state_q, state_d;
  mst_idx_t   g_q, g_d;
  mst_idx_t   last_q, last_d;
  mst_idx_t   sel;
  logic       wr_q, wr_d;
  logic       tmr_clr, tmr_en, tmr_expired;

  // Contention goes to the master that did not win last time.
  assign sel = (m_req == 2'b11) ? ~last_q : mst_idx_t'(m_req[1]);

  bus_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      last_q  <= 1'b1;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    wr_d    = wr_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|m_req) begin
          g_d     = sel;
          last_d  = sel;
          wr_d    = m_wr[sel];
          tmr_clr = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Ready takes priority over an expiring counter.
        if (sl_rdy)           state_d = ST_ADDR;
        else if (tmr_expired) state_d = ST_ERR;
        else                  tmr_en  = 1'b1;
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        tmr_clr = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (slrsp)            state_d = ST_DONE;
        else if (tmr_expired) state_d = ST_ERR;
        else                  tmr_en  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure decodes of the registered state and grant index.
  always_comb begin
    m_gnt = (state_q != ST_IDLE) ? mst_onehot(g_q) : 2'b00;
    sa    = (state_q == ST_ADDR);
    sw    = (state_q == ST_DATA) &&  wr_q;
    sr    = (state_q == ST_DATA) && !wr_q;
    m_rsp = (state_q == ST_DONE) ? mst_onehot(g_q) : 2'b00;
    m_err = (state_q == ST_ERR)  ? mst_onehot(g_q) : 2'b00;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter: each transaction's outcome is
// predicted from the arbitration and timeout rules and checked by a monitor.
module tb_bus_arbiter;

  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(TIMEOUT+1);
  localparam int W       = 17;

  logic       clk;
  logic       rst;
  logic [1:0] m_req;
  logic [1:0] m_wr;
  logic       sl_rdy;
  logic       slrsp;
  logic [1:0] m_gnt;
  logic       sa;
  logic       sw;
  logic       sr;
  logic [1:0] m_rsp;
  logic [1:0] m_err;

  int checks = 0;
  int errors = 0;
  int model_last = 1;
  logic [W-1:0] exp_q[$];

  bus_arbiter #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .m_req (m_req),
    .m_wr  (m_wr),
    .sl_rdy(sl_rdy),
    .slrsp (slrsp),
    .m_gnt (m_gnt),
    .sa    (sa),
    .sw    (sw),
    .sr    (sr),
    .m_rsp (m_rsp),
    .m_err (m_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // {err, grant, sa count, sw count, sr count, cycles with grant held}
  function automatic logic [W-1:0] pack_txn(input bit err, input logic [1:0] gnt,
                                            input int n_sa, input int n_sw,
                                            input int n_sr, input int cyc);
    return {err, gnt, 2'(n_sa), 2'(n_sw), 2'(n_sr), 8'(cyc)};
  endfunction

  // monitor / scoreboard
  int         mon_sa, mon_sw, mon_sr, mon_cyc;
  logic [1:0] mon_gnt;
  bit         mon_gnt_moved;

  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (rst) begin
      mon_sa = 0; mon_sw = 0; mon_sr = 0; mon_cyc = 0;
      mon_gnt = 2'b00; mon_gnt_moved = 0;
    end else begin
      checks++;
      if ((int'(sa) + int'(sw) + int'(sr) + int'(m_rsp != 0) + int'(m_err != 0)) > 1 ||
          $countones(m_gnt) > 1 || $countones(m_rsp) > 1 || $countones(m_err) > 1) begin
        errors++;
        $display("FAIL exclusive: sa=%b sw=%b sr=%b gnt=%b rsp=%b err=%b, required at most one active",
                 sa, sw, sr, m_gnt, m_rsp, m_err);
      end
      if (m_gnt != 2'b00) begin
        if (mon_cyc == 0) mon_gnt = m_gnt;
        else if (m_gnt != mon_gnt) mon_gnt_moved = 1;
        mon_cyc++;
      end
      mon_sa += int'(sa);
      mon_sw += int'(sw);
      mon_sr += int'(sr);
      if (m_rsp != 2'b00 || m_err != 2'b00) begin
        checks++;
        got = pack_txn(m_err != 2'b00, mon_gnt, mon_sa, mon_sw, mon_sr, mon_cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_completion: got %h, required no completion", got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp || (m_rsp | m_err) !== mon_gnt || mon_gnt_moved) begin
            errors++;
            $display("FAIL txn: got %h (pulse %b%b, gnt_moved %0d), required %h",
                     got, m_err, m_rsp, mon_gnt_moved, exp);
          end
        end
        mon_sa = 0; mon_sw = 0; mon_sr = 0; mon_cyc = 0;
        mon_gnt = 2'b00; mon_gnt_moved = 0;
      end
    end
  end

  // driver: called at a negedge with the DUT idle; leaves it idle at a negedge
  task automatic run_txn(input logic [1:0] req, input logic [1:0] wr,
                         input int d_rdy, input int d_rsp,
                         input bit scramble, input int gap);
    int winner, n_sw, n_sr, cyc;
    bit err, seen_sa, done;
    logic [1:0] oh;
    winner = (req == 2'b11) ? 1 - model_last : ((req == 2'b01) ? 0 : 1);
    model_last = winner;
    oh = (winner == 0) ? 2'b01 : 2'b10;
    if (d_rdy >= TIMEOUT) begin
      err = 1; cyc = TIMEOUT + 1;
      exp_q.push_back(pack_txn(err, oh, 0, 0, 0, cyc));
    end else begin
      n_sw = int'(wr[winner]);
      n_sr = 1 - n_sw;
      if (d_rsp >= TIMEOUT) begin
        err = 1; cyc = (d_rdy + 1) + 2 + TIMEOUT + 1;
      end else begin
        err = 0; cyc = (d_rdy + 1) + 2 + (d_rsp + 1) + 1;
      end
      exp_q.push_back(pack_txn(err, oh, 1, n_sw, n_sr, cyc));
    end

    m_req = req; m_wr = wr; sl_rdy = 1'b0; slrsp = 1'b0;
    @(negedge clk);
    checks++;
    if (m_gnt !== oh) begin
      errors++;
      $display("FAIL grant_latency: m_gnt=%b, required %b", m_gnt, oh);
    end
    if (scramble) begin
      m_req = 2'($urandom_range(0, 3));
      m_wr  = 2'($urandom_range(0, 3));
    end
    seen_sa = 0; done = 0;
    for (int i = 0; i < TIMEOUT + 4 && !seen_sa && !done; i++) begin
      sl_rdy = (i >= d_rdy);
      @(negedge clk);
      if (sa) seen_sa = 1;
      if (m_err != 2'b00 || m_rsp != 2'b00) done = 1;
    end
    sl_rdy = 1'b0;
    if (seen_sa && !done) begin
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < TIMEOUT + 4 && !done; j++) begin
        slrsp = (j >= d_rsp);
        @(negedge clk);
        if (m_err != 2'b00 || m_rsp != 2'b00) done = 1;
      end
      slrsp = 1'b0;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL completion_bound: no m_rsp/m_err within cycle budget, required one");
    end
    m_req = 2'b00;
    @(negedge clk);
    for (int k = 0; k < gap; k++) @(negedge clk);
  endtask

  task automatic reset_mid_data();
    m_req = 2'b01; m_wr = 2'b01; sl_rdy = 1'b1; slrsp = 1'b1;
    @(negedge clk);
    m_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sw !== 1'b1 || m_gnt !== 2'b01) begin
      errors++;
      $display("FAIL rst_data_setup: sw=%b gnt=%b, required sw=1 gnt=01", sw, m_gnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sw !== 1'b0 || m_gnt !== 2'b00 || m_rsp !== 2'b00 || m_err !== 2'b00 || sa !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_data: sw=%b gnt=%b rsp=%b err=%b sa=%b, required all 0",
               sw, m_gnt, m_rsp, m_err, sa);
    end
    rst = 1'b0; sl_rdy = 1'b0; slrsp = 1'b0;
    model_last = 1;
    for (int k = 0; k < 4; k++) @(negedge clk);
    checks++;
    if (m_gnt !== 2'b00 || m_rsp !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle: gnt=%b rsp=%b, required 00 00", m_gnt, m_rsp);
    end
  endtask

  initial begin
    rst = 1'b1; m_req = 2'b00; m_wr = 2'b00; sl_rdy = 1'b0; slrsp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_gnt !== 2'b00 || sa !== 1'b0 || sw !== 1'b0 || sr !== 1'b0 ||
        m_rsp !== 2'b00 || m_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b sa=%b sw=%b sr=%b rsp=%b err=%b, required all 0",
               m_gnt, sa, sw, sr, m_rsp, m_err);
    end
    rst = 1'b0;
    @(negedge clk);

    run_txn(2'b01, 2'b01, 0, 0, 0, 0);                 // master 0 write, best case
    for (int t = 0; t < 6; t++) run_txn(2'b11, 2'b00, 0, 0, 0, 0);
    run_txn(2'b10, 2'b00, TIMEOUT + 5, 0, 0, 1);       // ready never comes
    run_txn(2'b01, 2'b10, 0, TIMEOUT - 1, 0, 0);       // response on the last cycle
    run_txn(2'b01, 2'b10, 0, 1000, 0, 0);              // response never comes
    run_txn(2'b10, 2'b10, TIMEOUT - 1, 2, 0, 0);       // ready on the last cycle
    run_txn(2'b01, 2'b01, 2, 3, 1, 0);                 // inputs change after grant
    reset_mid_data();
    for (int t = 0; t < 50; t++) begin
      run_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
              $urandom_range(0, TIMEOUT + 1), $urandom_range(0, TIMEOUT + 1),
              1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    for (int k = 0; k < 4; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected completions outstanding, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
